csr_spmv_scheduler: RTL and testbench
=====================================

# csr_spmv_scheduler

Sequencer for the sparsity-aware spiking MVM datapath. Holds a 4x4 matrix in CSR form (up to 16 nonzeros), walks the row segments after a `start`, and accumulates only the entries whose column spike is set. Entries on silent columns are skipped and counted. Emits one result per row over a valid/ready stream. Sits between the configuration loader and the downstream neuron/readout stage.

## Interface
- `NNZ_MAX`, default 16: CSR entry storage depth. Fixed at 16 for this revision.
- `VAL_W`, default 8: width of an unsigned matrix value.
- `ACC_W`, default 12: width of the unsigned row accumulator; must be at least `VAL_W`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cfg_we` in 1: configuration write strobe.
- `cfg_sel` in 1: write target. 0 = entry table, 1 = row-end table.
- `cfg_addr` in 4: entry index. For row-end writes, only `[1:0]` is used as the row index.
- `cfg_wdata` in `VAL_W+2`: entry write = {col[1:0], value}. Row-end write = `[4:0]` is the exclusive end pointer.
- `start` in 1: begin one MVM pass. Sampled only in IDLE.
- `spike_train` in 4: input spike vector, latched on the accepted `start`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `out_valid` out 1: a row result is available.
- `out_ready` in 1: downstream accepts the result.
- `out_row` out 2: row index of the presented result.
- `out_data` out `ACC_W`: row result.
- `done` out 1: one-cycle pulse at the end of a pass.
- `skip_cnt` out 5: number of entries skipped in the current or last pass.

## Operation
- Storage:
  - entry table: 16 x {col, value};
  - row_end[0..3]: 5 bits each;
  - the pass spike latch;
  - all table contents reset to 0.
- Row r spans entries [base_r, row_end[r]).
  - base_0 = 0.
  - base_r = row_end[r-1].
  - Any row_end value greater than 16 is clamped to 16.
  - If row_end[r] <= base_r, row r is empty and its result is 0. This is not an error.
- `cfg_we` takes effect only in IDLE. Writes while `busy` are dropped.
- States:
  - IDLE:
    - on `start`: latch the spike vector, ptr = 0, row = 0, acc = 0, skip_cnt = 0; go to FETCH.
  - FETCH (one entry per cycle):
    - if ptr < end_r and spike[col[ptr]] = 1: acc = sat(acc + value), ptr++.
    - if ptr < end_r and the spike bit is 0: skip_cnt++, ptr++.
    - else (ptr >= end_r): go to EMIT.
  - EMIT:
    - `out_valid` = 1, `out_row` = row, `out_data` = acc.
    - on `out_valid && out_ready`, if row < 3: row++, acc = 0, ptr = max(ptr, base of next row); go to FETCH.
    - on the handshake with row = 3: go to FINISH.
  - FINISH: `done` = 1 for one cycle, `busy` = 0; go to IDLE.
- Arithmetic:
  - all arithmetic is unsigned;
  - sat(x) clamps at 2^ACC_W - 1;
  - skip_cnt saturates at 16, which is unreachable with 16 entries.
- `start` while `busy` is ignored.
- `skip_cnt` holds its value after `done` until the next accepted `start`.

## Timing
- Reset values:
  - `busy` = 0, `out_valid` = 0, `out_row` = 0, `out_data` = 0, `done` = 0, `skip_cnt` = 0;
  - FSM in IDLE.
- Start acceptance:
  - `start` is sampled at edge T.
  - FETCH of row 0 begins in the cycle after T.
  - `busy` is high from T+1.
- A row with k entries in range takes k+1 FETCH cycles, then EMIT. `out_valid` rises on the edge after the final FETCH cycle.
- Stall behaviour:
  - `out_valid` is held, and `out_row`/`out_data` are stable, until `out_ready`.
  - `out_ready` with `out_valid` low has no effect.
- With `out_ready` held at 1 and N total in-range entries, `done` is high in cycle T+N+9.
  - Each row costs k+2 cycles, and FINISH adds 1.
- `done` and `busy` fall together.
  - `busy` = 0 in the FINISH cycle.
  - A `start` in the cycle after `done` is accepted.
- `rst` mid-pass:
  - forces IDLE immediately;
  - drops `out_valid` and `done`;
  - clears the tables and `skip_cnt`;
  - no partial result is emitted after release.
- Simultaneous `cfg_we` and `start` in IDLE: the write commits, the pass starts, and the pass uses the newly written data.

## Test plan
- Diagonal matrix:
  - entries {c0,5}, {c1,6}, {c2,7}, {c3,8}; row_end = 1, 2, 3, 4; spikes 4'b1111; `out_ready` = 1.
  - Expect rows 0..3 = 5, 6, 7, 8, `skip_cnt` = 0, and `done` at T+13.
- Sparsity skip:
  - same matrix with spikes 4'b0101.
  - Expect results 5, 0, 7, 0 and `skip_cnt` = 2.
- Empty and non-monotonic rows:
  - row_end = 0, 3, 2, 3 with three entries all of value 1, spikes 4'b1111.
  - Expect 0, 3, 0, 0, and `done` at T+12.
- Saturation:
  - ACC_W = 8, row 0 holding 16 entries of {c0,255}, spike 4'b0001.
  - Expect row 0 = 255 and rows 1..3 = 0.
- Backpressure:
  - hold `out_ready` = 0 for 5 cycles during row 1's EMIT.
  - Expect `out_valid`, `out_row` = 1 and `out_data` stable throughout, and `done` delayed by exactly 5 cycles.
- Reset and illegal access:
  - assert `rst` during FETCH of row 2; expect `out_valid` = 0, `busy` = 0, `skip_cnt` = 0 the same cycle.
  - after release, start a pass with a `cfg_we` write issued while `busy`; expect the write to be ignored and the results unchanged.

Source files
------------

// File: rtl/csr_spmv_scheduler.sv
// csr_spmv_scheduler
// Sequencer for the sparsity-aware spiking MVM datapath. Holds a 4x4 matrix in CSR form
// (up to NNZ_MAX nonzeros), walks the row segments after start and accumulates only the
// entries whose column spike is set. Entries on silent columns are skipped and counted.
// One result per row is emitted over a valid/ready stream.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cfg_we/cfg_sel  config write strobe / target (0 = entry table, 1 = row-end table)
//   cfg_addr        entry index (row index in [1:0] for row-end writes)
//   cfg_wdata       entry = {col[1:0], value}; row-end = [4:0] exclusive end pointer
//   start           begin one pass (sampled in IDLE only)
//   spike_train     column spike vector, latched on accepted start
//   busy            pass in progress (FETCH/EMIT)
//   out_valid/out_ready/out_row/out_data   per-row result stream
//   done            one-cycle end-of-pass pulse
//   skip_cnt        entries skipped in the current or last pass
module csr_spmv_scheduler #(
  parameter int unsigned NNZ_MAX = 16,
  parameter int unsigned VAL_W   = 8,
  parameter int unsigned ACC_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [3:0]       cfg_addr,
  input  logic [VAL_W+1:0] cfg_wdata,
  input  logic             start,
  input  logic [3:0]       spike_train,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_row,
  output logic [ACC_W-1:0] out_data,
  output logic             done,
  output logic [4:0]       skip_cnt
);

  localparam int unsigned SumW    = ACC_W + 1;
  localparam logic [4:0]  NnzLim  = 5'(NNZ_MAX);
  localparam logic [4:0]  SkipMax = 5'd16;

  typedef enum logic [1:0] {StIdle, StFetch, StEmit, StFinish} state_e;

  state_e state_q, state_d;

  logic [VAL_W+1:0] entry_q   [NNZ_MAX];
  logic [4:0]       row_end_q [4];
  logic [3:0]       spike_q;
  logic [4:0]       ptr_q, ptr_d;
  logic [1:0]       row_q, row_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       skip_q, skip_d;

  logic             cfg_ok;
  logic             start_ok;
  logic [4:0]       end_raw;
  logic [4:0]       end_cur;
  logic             in_range;
  logic [VAL_W+1:0] cur_entry;
  logic [1:0]       cur_col;
  logic [VAL_W-1:0] cur_val;
  logic             hit;
  logic [SumW-1:0]  sum;
  logic [ACC_W-1:0] acc_sat;

  assign cfg_ok   = cfg_we && (state_q == StIdle);
  assign start_ok = start && (state_q == StIdle);

  // End pointer of the current row, clamped to table depth. The end of row r is also
  // the base of row r+1, so the same value feeds the pointer advance in EMIT.
  assign end_raw   = row_end_q[row_q];
  assign end_cur   = (end_raw > NnzLim) ? NnzLim : end_raw;
  assign in_range  = ptr_q < end_cur;
  assign cur_entry = entry_q[ptr_q[3:0]];
  assign cur_col   = cur_entry[VAL_W+1:VAL_W];
  assign cur_val   = cur_entry[VAL_W-1:0];
  assign hit       = spike_q[cur_col];
  assign sum       = {1'b0, acc_q} + SumW'(cur_val);
  assign acc_sat   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

  // Configuration tables; writes outside IDLE are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NNZ_MAX; i++) entry_q[i] <= '0;
      for (int unsigned r = 0; r < 4; r++) row_end_q[r] <= '0;
    end else if (cfg_ok) begin
      if (cfg_sel) row_end_q[cfg_addr[1:0]] <= cfg_wdata[4:0];
      else         entry_q[cfg_addr]        <= cfg_wdata;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  if (!in_range) state_d = StEmit;
      StEmit:   if (out_ready) state_d = (row_q == 2'd3) ? StFinish : StFetch;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q == StFetch) || (state_q == StEmit);
    out_valid = (state_q == StEmit);
    done      = (state_q == StFinish);
  end

  // Datapath next state
  always_comb begin
    ptr_d  = ptr_q;
    row_d  = row_q;
    acc_d  = acc_q;
    skip_d = skip_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_d  = '0;
          row_d  = '0;
          acc_d  = '0;
          skip_d = '0;
        end
      end
      StFetch: begin
        if (in_range) begin
          if (hit)                    acc_d  = acc_sat;
          else if (skip_q != SkipMax) skip_d = skip_q + 5'd1;
          ptr_d = ptr_q + 5'd1;
        end
      end
      StEmit: begin
        if (out_ready && (row_q != 2'd3)) begin
          row_d = row_q + 2'd1;
          acc_d = '0;
          // Never revisit entries already consumed by an overlapping earlier row.
          ptr_d = (ptr_q > end_cur) ? ptr_q : end_cur;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      row_q   <= '0;
      acc_q   <= '0;
      skip_q  <= '0;
      spike_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      row_q  <= row_d;
      acc_q  <= acc_d;
      skip_q <= skip_d;
      if (start_ok) spike_q <= spike_train;
    end
  end

  assign out_row  = row_q;
  assign out_data = acc_q;
  assign skip_cnt = skip_q;

endmodule

// File: tb/tb_csr_spmv_scheduler.sv
// Self-checking bench for csr_spmv_scheduler: directed cases plus randomized passes,
// a scoreboard of expected row results and a monitor that checks every handshake.
module tb_csr_spmv_scheduler;

  localparam int VAL_W  = 8;
  localparam int ACC_W  = 8;
  localparam int AccMax = (1 << ACC_W) - 1;

  logic             clk;
  logic             rst;
  logic             cfg_we;
  logic             cfg_sel;
  logic [3:0]       cfg_addr;
  logic [VAL_W+1:0] cfg_wdata;
  logic             start;
  logic [3:0]       spike_train;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_row;
  logic [ACC_W-1:0] out_data;
  logic             done;
  logic [4:0]       skip_cnt;

  csr_spmv_scheduler #(
    .NNZ_MAX(16),
    .VAL_W  (VAL_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .start      (start),
    .spike_train(spike_train),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_data   (out_data),
    .done       (done),
    .skip_cnt   (skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a shadow copy of the tables and the pass result.
  int m_col [16];
  int m_val [16];
  int m_end [4];
  int exp_res [4];
  int exp_skip;
  int exp_n;

  typedef struct {int row; int data;} exp_t;
  exp_t sb[$];

  // Each entry index is consumed at most once, in order; row r claims the indices of
  // [base_r, end_r) that no earlier row has claimed.
  function automatic void model(input logic [3:0] spk);
    bit claimed [16];
    int base;
    int lim;
    for (int i = 0; i < 16; i++) claimed[i] = 1'b0;
    exp_skip = 0;
    exp_n    = 0;
    base     = 0;
    for (int r = 0; r < 4; r++) begin
      lim        = (m_end[r] > 16) ? 16 : m_end[r];
      exp_res[r] = 0;
      for (int i = base; i < lim; i++) begin
        if (!claimed[i]) begin
          claimed[i] = 1'b1;
          exp_n++;
          if (spk[m_col[i]]) begin
            if (exp_res[r] + m_val[i] > AccMax) exp_res[r] = AccMax;
            else                                exp_res[r] = exp_res[r] + m_val[i];
          end else begin
            exp_skip++;
          end
        end
      end
      base = lim;
    end
  endfunction

  function automatic void apply_cfg(input bit sel, input int addr, input int data);
    if (sel) m_end[addr & 3] = data & 31;
    else begin
      m_col[addr & 15] = (data >> 8) & 3;
      m_val[addr & 15] = data & 255;
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) begin
      m_col[i] = 0;
      m_val[i] = 0;
    end
    for (int r = 0; r < 4; r++) m_end[r] = 0;
  endfunction

  // Ready driver: optional stall on one row's EMIT, or random backpressure.
  int stall_row  = -1;
  int stall_left = 0;
  bit rand_ready = 1'b0;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && out_valid && int'(out_row) == stall_row) begin
        out_ready  = 1'b0;
        stall_left = stall_left - 1;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stability while stalled.
  bit   held = 1'b0;
  int   h_row;
  int   h_data;
  exp_t e;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held)
          chk(out_valid && int'(out_row) == h_row && int'(out_data) == h_data,
              "stall_stable", int'(out_data), h_data);
        held = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            if (sb.size() == 0) begin
              chk(1'b0, "unexpected_result", int'(out_row), -1);
            end else begin
              e = sb.pop_front();
              chk(int'(out_row) == e.row, "out_row", int'(out_row), e.row);
              chk(int'(out_data) == e.data, "out_data", int'(out_data), e.data);
            end
          end else begin
            held   = 1'b1;
            h_row  = int'(out_row);
            h_data = int'(out_data);
          end
        end
      end
    end
  end

  // All stimulus tasks start and end at #1 after a rising edge.
  task automatic cfg_write(input bit sel, input int addr, input int data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = addr[3:0];
    cfg_wdata = data[9:0];
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    apply_cfg(sel, addr, data);
  endtask

  task automatic cfg_diag();
    for (int i = 0; i < 4; i++) cfg_write(1'b0, i, (i << 8) | (5 + i));
    for (int r = 0; r < 4; r++) cfg_write(1'b1, r, r + 1);
  endtask

  task automatic run_pass(input logic [3:0] spk, input bit timed, input int st_row,
                          input int st_len, input bit poke, input bit sw, input bit sw_sel,
                          input int sw_addr, input int sw_data);
    int t0;
    bit got;
    if (sw) begin
      apply_cfg(sw_sel, sw_addr, sw_data);
      cfg_we    = 1'b1;
      cfg_sel   = sw_sel;
      cfg_addr  = sw_addr[3:0];
      cfg_wdata = sw_data[9:0];
    end
    model(spk);
    for (int r = 0; r < 4; r++) sb.push_back('{row: r, data: exp_res[r]});
    stall_row   = st_row;
    stall_left  = st_len;
    start       = 1'b1;
    spike_train = spk;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cfg_we = 1'b0;
    t0     = cyc;
    @(negedge clk);
    chk(busy == 1'b1, "busy_after_start", int'(busy), 1);
    if (poke) begin
      @(posedge clk);
      #1;
      cfg_we    = 1'b1;
      cfg_sel   = 1'b0;
      cfg_addr  = 4'd0;
      cfg_wdata = 10'd99;
      start     = 1'b1;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      start  = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk(got, "done_seen", int'(got), 1);
    if (got) begin
      if (timed) chk(cyc == t0 + exp_n + 8 + st_len, "done_cycle", cyc + 1,
                     t0 + exp_n + 9 + st_len);
      chk(int'(skip_cnt) == exp_skip, "skip_cnt", int'(skip_cnt), exp_skip);
      chk(busy == 1'b0, "busy_at_done", int'(busy), 0);
    end
    chk(sb.size() == 0, "results_all_seen", sb.size(), 0);
    sb.delete();
    stall_left = 0;
    @(posedge clk);
    #1;
    chk(int'(skip_cnt) == exp_skip, "skip_hold", int'(skip_cnt), exp_skip);
  endtask

  initial begin
    bit got;
    bit quiet;
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_sel     = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    start       = 1'b0;
    spike_train = '0;
    clear_model();

    @(negedge clk);
    chk(busy == 1'b0, "rst_busy", int'(busy), 0);
    chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
    chk(out_row == 2'd0, "rst_out_row", int'(out_row), 0);
    chk(out_data == '0, "rst_out_data", int'(out_data), 0);
    chk(done == 1'b0, "rst_done", int'(done), 0);
    chk(skip_cnt == 5'd0, "rst_skip_cnt", int'(skip_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Diagonal, full spikes, then sparse spikes, then backpressure on row 1.
    cfg_diag();
    run_pass(4'b1111, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_pass(4'b0101, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_pass(4'b1111, 1'b1, 1, 5, 1'b0, 1'b0, 1'b0, 0, 0);

    // Empty and non-monotonic rows.
    for (int i = 0; i < 3; i++) cfg_write(1'b0, i, (i << 8) | 1);
    cfg_write(1'b1, 0, 0);
    cfg_write(1'b1, 1, 3);
    cfg_write(1'b1, 2, 2);
    cfg_write(1'b1, 3, 3);
    run_pass(4'b1111, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    // Write coincident with start must be used by that pass.
    run_pass(4'b1111, 1'b1, -1, 0, 1'b0, 1'b1, 1'b0, 1, (1 << 8) | 9);

    // Saturation with end pointers at and beyond the table depth.
    for (int i = 0; i < 16; i++) cfg_write(1'b0, i, 255);
    cfg_write(1'b1, 0, 16);
    cfg_write(1'b1, 1, 16);
    cfg_write(1'b1, 2, 16);
    cfg_write(1'b1, 3, 31);
    run_pass(4'b0001, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    // Randomized passes.
    for (int p = 0; p < 30; p++) begin
      for (int r = 0; r < 4; r++) cfg_write(1'b1, r, $urandom_range(0, 18));
      for (int j = 0; j < 6; j++) cfg_write(1'b0, $urandom_range(0, 15), $urandom_range(0, 1023));
      rand_ready = ($urandom_range(0, 1) == 1);
      run_pass(4'($urandom_range(0, 15)), !rand_ready, -1, 0, 1'b0,
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
               $urandom_range(0, 15), $urandom_range(0, 1023));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset during FETCH of row 2.
    for (int i = 0; i < 16; i++) cfg_write(1'b0, i, ((i % 4) << 8) | (i + 1));
    cfg_write(1'b1, 0, 2);
    cfg_write(1'b1, 1, 4);
    cfg_write(1'b1, 2, 10);
    cfg_write(1'b1, 3, 12);
    model(4'b0101);
    for (int r = 0; r < 4; r++) sb.push_back('{row: r, data: exp_res[r]});
    start       = 1'b1;
    spike_train = 4'b0101;
    @(posedge clk);
    #1;
    start = 1'b0;
    got   = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_row == 2'd1) got = 1'b1;
    end
    chk(got, "row1_emit_seen", int'(got), 1);
    @(posedge clk);
    #1;
    chk(int'(skip_cnt) == 2, "skip_before_rst", int'(skip_cnt), 2);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk(out_valid == 1'b0, "rst_mid_out_valid", int'(out_valid), 0);
    chk(busy == 1'b0, "rst_mid_busy", int'(busy), 0);
    chk(skip_cnt == 5'd0, "rst_mid_skip_cnt", int'(skip_cnt), 0);
    chk(done == 1'b0, "rst_mid_done", int'(done), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid || busy || done) quiet = 1'b0;
    end
    chk(quiet, "quiet_after_rst", int'(quiet), 1);
    @(posedge clk);
    #1;

    // Tables were cleared: every row is empty.
    run_pass(4'b1111, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0);
    // Writes and start while busy are ignored.
    cfg_diag();
    run_pass(4'b1111, 1'b1, -1, 0, 1'b1, 1'b0, 1'b0, 0, 0);
    run_pass(4'b1111, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
